// File: rtl/useq_host_port.sv
// useq_host_port: host-side master for the useq message-passing FIFO.
// Host bytes become useq write strobes, and useq read strobes are drained
// into a byte stream toward the host. Reads and writes share one strobe
// slot per cycle. Long strobe bursts are broken up with forced gaps so the
// useq CPU gets time to run.
//
// Handshake semantics (both host-side ports): a byte moves on a rising
// clk edge exactly when valid and ready are both high in the cycle before
// that edge. A source keeps its data stable while valid is high and
// not yet accepted. s_ready is a combinational function of s_valid and
// registered state. m_valid/m_data are registered and never depend on
// m_ready in the same cycle.
module useq_host_port #(
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic [7:0] fifo_out,
    output logic       read_fifo,
    output logic       write_fifo,
    output logic [7:0] fifo_in,
    output logic       gap_active
);

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    grant_e      last_grant_q;
    logic        rd_pending_q;
    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic [GW-1:0] gap_cnt_q;

    logic wr_ok;
    logic rd_ok;
    logic grant_wr;
    logic grant_rd;
    logic strobe;

    // Eligibility and arbitration; a tie goes to whichever side did not win last.
    always_comb begin
        gap_active = (gap_cnt_q != '0);
        wr_ok      = s_valid & ~fifo_full & ~gap_active;
        rd_ok      = ~fifo_empty & ~rd_pending_q & ~m_valid_q & ~gap_active;
        grant_wr   = ~rst & wr_ok & (~rd_ok | (last_grant_q == GRANT_READ));
        grant_rd   = ~rst & rd_ok & (~wr_ok | (last_grant_q == GRANT_WRITE));
        strobe     = grant_wr | grant_rd;
    end

    assign write_fifo = grant_wr;
    assign read_fifo  = grant_rd;
    assign s_ready    = grant_wr;
    assign fifo_in    = s_data;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;

    // Grant history, read-capture pipeline and host-side output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_READ;
            rd_pending_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'h00;
        end else begin
            if (grant_wr) begin
                last_grant_q <= GRANT_WRITE;
            end else if (grant_rd) begin
                last_grant_q <= GRANT_READ;
            end
            // useq presents the popped byte one cycle after the strobe.
            rd_pending_q <= grant_rd;
            if (rd_pending_q) begin
                m_data_q  <= fifo_out;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    generate
        if (MAX_BURST > 0) begin : g_limit
            localparam int unsigned BW = $clog2(MAX_BURST + 1);

            logic [BW-1:0] burst_cnt_q;
            logic [BW-1:0] burst_cnt_d;
            logic [GW-1:0] gap_cnt_d;

            // Count consecutive strobe cycles; the last allowed strobe arms the gap.
            always_comb begin
                burst_cnt_d = '0;
                gap_cnt_d   = gap_cnt_q;
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
                if (strobe) begin
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                        burst_cnt_d = '0;
                        gap_cnt_d   = GW'(GAP_CYCLES);
                    end else begin
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end
                end
            end

            // Burst and gap counters.
            always_ff @(posedge clk) begin
                if (rst) begin
                    burst_cnt_q <= '0;
                    gap_cnt_q   <= '0;
                end else begin
                    burst_cnt_q <= burst_cnt_d;
                    gap_cnt_q   <= gap_cnt_d;
                end
            end
        end else begin : g_no_limit
            assign gap_cnt_q = '0;
        end
    endgenerate

endmodule
